// File: rtl/event_chunk_arbiter.sv
// Round-robin arbiter that moves one fixed-length chunk at a time from one of
// NUM_LINKS 64-bit streams to a chunk store, flagging and counting length errors.
module event_chunk_arbiter #(
  parameter int NUM_LINKS   = 4,
  parameter int CHUNK_BEATS = 384
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable_i,
  input  logic                         space_avail_i,
  input  logic [NUM_LINKS*64-1:0]      s_tdata,
  input  logic [NUM_LINKS-1:0]         s_tvalid,
  input  logic [NUM_LINKS-1:0]         s_tlast,
  output logic [NUM_LINKS-1:0]         s_tready,
  output logic [63:0]                  payload_o,
  output logic                         payload_valid_o,
  output logic                         payload_last_o,
  output logic [$clog2(NUM_LINKS)-1:0] active_link_o,
  output logic                         busy_o,
  output logic                         chunk_done_o,
  output logic                         len_err_o,
  output logic [15:0]                  err_count_o
);

  localparam int LW = $clog2(NUM_LINKS);
  localparam int CW = $clog2(CHUNK_BEATS);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CHUNK_BEATS - 1);
  localparam logic [LW-1:0] LAST_LINK = LW'(NUM_LINKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LW-1:0]        r_active;
  logic [LW-1:0]        r_last_grant;
  logic [LW-1:0]        w_active_nxt;
  logic [LW-1:0]        w_pick;
  logic [LW-1:0]        w_idx;
  logic                 w_pick_ok;
  logic                 w_grant;
  logic [CW-1:0]        r_cnt;
  logic                 r_armed;
  logic [NUM_LINKS-1:0] r_tready;
  logic [NUM_LINKS-1:0] w_tready_nxt;
  logic                 r_busy;
  logic [63:0]          w_lane [NUM_LINKS];
  logic                 w_acc;
  logic                 w_xfer_acc;
  logic                 w_at_max;
  logic                 w_g_last;
  logic                 w_end;
  logic                 w_len_err;
  logic [63:0]          r_payload;
  logic                 r_pvalid;
  logic                 r_plast;
  logic                 r_done;
  logic                 r_len_err;
  logic [15:0]          r_err_cnt;

  // Round-robin search starting one past the previous grant.
  always_comb begin
    w_pick    = '0;
    w_pick_ok = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      w_idx = LW'((32'(r_last_grant) + 32'd1 + 32'(i)) % NUM_LINKS);
      if (!w_pick_ok && s_tvalid[w_idx]) begin
        w_pick    = w_idx;
        w_pick_ok = 1'b1;
      end else begin
        w_pick    = w_pick;
        w_pick_ok = w_pick_ok;
      end
    end
  end

  // Granted-link beat decode and chunk-end / length-error classification.
  always_comb begin
    for (int k = 0; k < NUM_LINKS; k++) begin
      w_lane[k] = s_tdata[64*k +: 64];
    end
    w_acc      = s_tvalid[r_active] & r_tready[r_active];
    w_g_last   = s_tlast[r_active];
    w_xfer_acc = (r_state == ST_XFER) && w_acc;
    w_at_max   = (r_cnt == LAST_CNT);
    w_end      = w_xfer_acc && (w_g_last || w_at_max);
    w_len_err  = w_end && (w_g_last != w_at_max);
  end

  // Next-state logic; enable/space are only looked at while idle.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_tready_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && enable_i && space_avail_i && w_pick_ok) begin
          w_state_nxt = ST_XFER;
          w_grant     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (w_end) begin
          w_state_nxt = w_g_last ? ST_IDLE : ST_DRAIN;
        end else begin
          w_state_nxt = ST_XFER;
        end
      end
      ST_DRAIN: begin
        if (w_acc && w_g_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_active_nxt = w_grant ? w_pick : r_active;
    if (w_state_nxt != ST_IDLE) begin
      w_tready_nxt[w_active_nxt] = 1'b1;
    end else begin
      w_tready_nxt = '0;
    end
  end

  // Control state: FSM, grant bookkeeping, beat counter, ready strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_armed      <= 1'b0;
      r_active     <= '0;
      r_last_grant <= LAST_LINK;
      r_cnt        <= '0;
      r_tready     <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_armed  <= 1'b1;
      r_active <= w_active_nxt;
      r_tready <= w_tready_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      if (w_grant) begin
        r_last_grant <= w_pick;
        r_cnt        <= '0;
      end else if (w_xfer_acc) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Registered payload path and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_payload <= 64'd0;
      r_pvalid  <= 1'b0;
      r_plast   <= 1'b0;
      r_done    <= 1'b0;
      r_len_err <= 1'b0;
      r_err_cnt <= 16'd0;
    end else begin
      r_pvalid  <= w_xfer_acc;
      r_plast   <= w_end;
      r_done    <= w_end;
      r_len_err <= w_len_err;
      if (w_xfer_acc) begin
        r_payload <= w_lane[r_active];
      end else begin
        r_payload <= r_payload;
      end
      if (w_len_err && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end
  end

  assign s_tready        = r_tready;
  assign payload_o       = r_payload;
  assign payload_valid_o = r_pvalid;
  assign payload_last_o  = r_plast;
  assign chunk_done_o    = r_done;
  assign len_err_o       = r_len_err;
  assign err_count_o     = r_err_cnt;
  assign busy_o          = r_busy;
  assign active_link_o   = r_active;

endmodule

// File: tb/tb_event_chunk_arbiter.sv
// Directed bench for event_chunk_arbiter: behavioural link sources feed the DUT,
// output beats are tallied and compared against hand-computed expectations.
module tb_event_chunk_arbiter;
  localparam int NL = 4;
  localparam int CB = 384;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable_i = 1'b0;
  logic              space_avail_i = 1'b0;
  logic [NL*64-1:0]  s_tdata;
  logic [NL-1:0]     s_tvalid;
  logic [NL-1:0]     s_tlast;
  logic [NL-1:0]     s_tready;
  logic [63:0]       payload_o;
  logic              payload_valid_o;
  logic              payload_last_o;
  logic [1:0]        active_link_o;
  logic              busy_o;
  logic              chunk_done_o;
  logic              len_err_o;
  logic [15:0]       err_count_o;

  event_chunk_arbiter #(.NUM_LINKS(NL), .CHUNK_BEATS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .space_avail_i(space_avail_i),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .payload_o(payload_o), .payload_valid_o(payload_valid_o), .payload_last_o(payload_last_o),
    .active_link_o(active_link_o), .busy_o(busy_o), .chunk_done_o(chunk_done_o),
    .len_err_o(len_err_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int src_len [NL];
  int src_chunk [NL];
  int src_sent [NL];
  int n_valid, n_last, n_err, beat_in, data_err, sync_err;
  int lpos [$];
  int lnk [$];
  int ord, bad, cyc;
  logic [NL-1:0] seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NL; k++) begin
      s_tvalid[k] = (src_sent[k] < src_len[k]);
      s_tlast[k]  = s_tvalid[k] && (((src_sent[k] + 1) % src_chunk[k]) == 0);
      s_tdata[64*k +: 64] = {8'(k), 40'd0, 16'(src_sent[k] % src_chunk[k])};
    end
  endtask

  task automatic clear_src();
    for (int k = 0; k < NL; k++) begin
      src_len[k] = 0; src_chunk[k] = 1; src_sent[k] = 0;
    end
    drive();
  endtask

  task automatic clear_stats();
    n_valid = 0; n_last = 0; n_err = 0; beat_in = 0; data_err = 0; sync_err = 0;
    lpos.delete(); lnk.delete();
  endtask

  // One clock: note handshakes before the edge, advance sources and tally outputs after it.
  task automatic step();
    logic [NL-1:0] acc;
    acc = s_tvalid & s_tready;
    @(posedge clk); #1;
    for (int k = 0; k < NL; k++) if (acc[k]) src_sent[k]++;
    drive();
    if (payload_valid_o) begin
      if (payload_o[15:0] !== 16'(beat_in)) data_err++;
      beat_in++; n_valid++;
      if (payload_last_o) begin
        lpos.push_back(beat_in);
        lnk.push_back(int'(payload_o[63:56]));
        beat_in = 0; n_last++;
      end
    end
    if (len_err_o) n_err++;
    if (len_err_o && !payload_last_o) sync_err++;
    if (payload_last_o && !payload_valid_o) sync_err++;
    if (chunk_done_o !== (payload_valid_o & payload_last_o)) sync_err++;
  endtask

  task automatic run_until_last(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (n_last < n && c < budget) begin step(); c++; end
    check(tag, 64'(n_last), 64'(n));
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int c;
    c = 0;
    step();
    while (busy_o && c < budget) begin step(); c++; end
    check(tag, 64'(busy_o), 64'd0);
  endtask

  initial begin
    clear_src(); clear_stats();
    #1 rst_n = 1'b0;
    #2;
    check("rst tready", 64'(s_tready), 64'd0);
    check("rst payload", payload_o, 64'd0);
    check("rst flags", 64'({payload_valid_o, payload_last_o, chunk_done_o, len_err_o, busy_o}), 64'd0);
    check("rst active", 64'(active_link_o), 64'd0);
    check("rst errcnt", 64'(err_count_o), 64'd0);

    // Four links with correct chunks; link 0 has two chunks queued.
    enable_i = 1'b1; space_avail_i = 1'b1;
    src_len[0] = 2*CB; src_chunk[0] = CB;
    for (int k = 1; k < NL; k++) begin src_len[k] = CB; src_chunk[k] = CB; end
    drive();
    #4 rst_n = 1'b1;
    step();
    check("no grant 1st edge", 64'(busy_o), 64'd0);
    step();
    check("grant 2nd edge busy", 64'(busy_o), 64'd1);
    check("grant 2nd edge tready", 64'(s_tready), 64'b0001);
    run_until_last(5, 2200, "A timeout");
    step(); step();
    ord = 0; foreach (lnk[i]) ord = ord * 16 + lnk[i];
    bad = 0; foreach (lpos[i]) if (lpos[i] != CB) bad++;
    check("A grant order", 64'(ord), 64'h01230);
    check("A last position", 64'(bad), 64'd0);
    check("A beats", 64'(n_valid), 64'd1920);
    check("A data", 64'(data_err), 64'd0);
    check("A len_err", 64'(n_err), 64'd0);
    check("A errcnt", 64'(err_count_o), 64'd0);
    check("A sync", 64'(sync_err), 64'd0);
    check("A idle", 64'(busy_o), 64'd0);

    // Short chunk of 100 beats on link 2.
    clear_src(); clear_stats();
    src_len[2] = 100; src_chunk[2] = 100; drive();
    run_until_last(1, 300, "B timeout");
    step();
    check("B beats", 64'(n_valid), 64'd100);
    check("B last pos", 64'(lpos[0]), 64'd100);
    check("B link", 64'(lnk[0]), 64'd2);
    check("B len_err pulses", 64'(n_err), 64'd1);
    check("B errcnt", 64'(err_count_o), 64'd1);
    check("B idle", 64'(busy_o), 64'd0);
    check("B sync", 64'(sync_err + data_err), 64'd0);

    // Long chunk: 400 beats on link 1, only 384 forwarded, rest drained.
    clear_src(); clear_stats();
    src_len[1] = 400; src_chunk[1] = 400; drive();
    run_until_last(1, 500, "C timeout");
    check("C len_err with last", 64'(n_err), 64'd1);
    step();
    check("C drain busy", 64'(busy_o), 64'd1);
    check("C drain tready", 64'(s_tready), 64'b0010);
    run_until_idle(40, "C drain timeout");
    check("C all accepted", 64'(src_sent[1]), 64'd400);
    check("C beats", 64'(n_valid), 64'd384);
    check("C last pos", 64'(lpos[0]), 64'd384);
    check("C errcnt", 64'(err_count_o), 64'd2);
    check("C sync", 64'(sync_err + data_err), 64'd0);

    // Space gating: no grant while space is low; a started chunk completes.
    clear_src(); clear_stats();
    space_avail_i = 1'b0;
    for (int k = 0; k < NL; k++) begin src_len[k] = 10; src_chunk[k] = 10; end
    drive();
    seen = '0;
    repeat (5) begin step(); seen |= s_tready; end
    check("D no space tready", 64'(seen), 64'd0);
    space_avail_i = 1'b1;
    step();
    check("D grant tready", 64'(s_tready), 64'b0100);
    step();
    space_avail_i = 1'b0;
    run_until_last(1, 30, "D timeout");
    check("D beats", 64'(n_valid), 64'd10);
    check("D last pos", 64'(lpos[0]), 64'd10);
    step(); step();
    check("D idle", 64'({busy_o, s_tready}), 64'd0);
    check("D active held", 64'(active_link_o), 64'd2);
    check("D errcnt", 64'(err_count_o), 64'd3);

    // Reset in the middle of a chunk on link 3.
    clear_src(); clear_stats();
    src_len[3] = CB; src_chunk[3] = CB;
    src_len[0] = 5; src_chunk[0] = 5; drive();
    space_avail_i = 1'b1;
    cyc = 0;
    while (n_valid < 200 && cyc < 400) begin step(); cyc++; end
    check("E reached beat 200", 64'(n_valid), 64'd200);
    check("E granted link 3", 64'(active_link_o), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("E rst payload", payload_o, 64'd0);
    check("E rst flags", 64'({payload_valid_o, payload_last_o, chunk_done_o, len_err_o, busy_o}), 64'd0);
    check("E rst tready", 64'(s_tready), 64'd0);
    check("E rst active", 64'(active_link_o), 64'd0);
    check("E rst errcnt", 64'(err_count_o), 64'd0);
    #2 rst_n = 1'b1;
    clear_stats();
    step();
    check("E no grant 1st edge", 64'(busy_o), 64'd0);
    step();
    check("E grant link 0", 64'(s_tready), 64'b0001);
    run_until_last(1, 30, "E timeout");
    space_avail_i = 1'b0;
    check("E first last is link 0", 64'(lnk[0]), 64'd0);
    check("E last pos", 64'(lpos[0]), 64'd5);
    check("E errcnt", 64'(err_count_o), 64'd1);
    clear_src(); step(); step();

    // Saturation: counter preloaded near the top, then single-beat short chunks.
    force dut.r_err_cnt = 16'hFFFD;
    #1 release dut.r_err_cnt;
    clear_stats();
    src_len[1] = 3; src_chunk[1] = 1; drive();
    space_avail_i = 1'b1;
    run_until_last(1, 20, "F timeout 1");
    check("F errcnt FFFE", 64'(err_count_o), 64'hFFFE);
    run_until_last(2, 20, "F timeout 2");
    check("F errcnt FFFF", 64'(err_count_o), 64'hFFFF);
    run_until_last(3, 20, "F timeout 3");
    step(); step();
    check("F errcnt saturated", 64'(err_count_o), 64'hFFFF);
    check("F len_err pulses", 64'(n_err), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
